// File: rtl/spi_master_arbiter_if.sv
// rtl/spi_master_arbiter_if.sv - requester and spi_master side signals of the arbiter
// slave modport is the arbiter's view; master modport is the surrounding logic's view.
interface spi_master_arbiter_if;
   logic [9:0] cfg_freq;
   logic       req0;
   logic       rw0;
   logic [7:0] addr0;
   logic [7:0] wdata0;
   logic       ack0;
   logic [7:0] rdata0;
   logic       err0;
   logic       req1;
   logic       rw1;
   logic [7:0] addr1;
   logic [7:0] wdata1;
   logic       ack1;
   logic [7:0] rdata1;
   logic       err1;
   logic       busy;
   logic [9:0] m_freq;
   logic       m_start_w;
   logic       m_start_r;
   logic [7:0] m_addr;
   logic [7:0] m_wdata;
   logic [7:0] m_rdata;
   logic       m_done;

   modport slave (
      input  cfg_freq, req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, m_rdata, m_done,
      output ack0, rdata0, err0, ack1, rdata1, err1, busy, m_freq, m_start_w, m_start_r,
             m_addr, m_wdata
   );

   modport master (
      output cfg_freq, req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, m_rdata, m_done,
      input  ack0, rdata0, err0, ack1, rdata1, err1, busy, m_freq, m_start_w, m_start_r,
             m_addr, m_wdata
   );
endinterface

// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - round-robin sharing of one spi_master between two requesters
// Latches the winning command, pulses start for START_HOLD cycles, waits for done or timeout.
module spi_master_arbiter #(
   parameter int START_HOLD = 4,
   parameter int TIMEOUT    = 60000
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   spi_master_arbiter_if.slave  bus
);
   localparam int HW = $clog2(START_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD - 1);
   localparam logic [15:0]   TOUT_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

   state_t        state_q, state_d;
   logic          rr_q, rr_d;
   logic          owner_q, owner_d;
   logic          rw_q, rw_d;
   logic [7:0]    addr_q, addr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic          start_w_q, start_w_d;
   logic          start_r_q, start_r_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [15:0]   tout_q, tout_d;
   logic          done_q;
   logic          ack0_q, ack0_d, ack1_q, ack1_d;
   logic          err0_q, err0_d, err1_q, err1_d;
   logic [7:0]    rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic          done_rise;
   logic          win;
   logic          win_rw;
   logic [7:0]    resp_data;
   logic          resp_err;
   logic          resp_go;

   assign done_rise = bus.m_done & ~done_q;

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      owner_d   = owner_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      start_w_d = start_w_q;
      start_r_d = start_r_q;
      hold_d    = hold_q;
      tout_d    = tout_q;
      ack0_d    = ack0_q;
      ack1_d    = ack1_q;
      err0_d    = err0_q;
      err1_d    = err1_q;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      win       = (bus.req0 & bus.req1) ? rr_q : bus.req1;
      win_rw    = win ? bus.rw1 : bus.rw0;
      resp_data = 8'h00;
      resp_err  = 1'b0;
      resp_go   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.req0 | bus.req1) begin
               owner_d   = win;
               rw_d      = win_rw;
               addr_d    = win ? bus.addr1 : bus.addr0;
               wdata_d   = win ? bus.wdata1 : bus.wdata0;
               start_w_d = ~win_rw;
               start_r_d = win_rw;
               hold_d    = '0;
               state_d   = START;
            end
         end
         START: begin
            if (hold_q == HOLD_LAST) begin
               start_w_d = 1'b0;
               start_r_d = 1'b0;
               tout_d    = '0;
               state_d   = WAIT;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         WAIT: begin
            // done has priority over a timeout landing in the same cycle
            if (done_rise) begin
               resp_go   = 1'b1;
               resp_data = rw_q ? bus.m_rdata : 8'h00;
            end else if (tout_q == TOUT_LAST) begin
               resp_go  = 1'b1;
               resp_err = 1'b1;
            end else begin
               tout_d = tout_q + 16'd1;
            end
         end
         RESP: begin
            ack0_d   = 1'b0;
            ack1_d   = 1'b0;
            err0_d   = 1'b0;
            err1_d   = 1'b0;
            rdata0_d = 8'h00;
            rdata1_d = 8'h00;
            rr_d     = ~owner_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (resp_go) begin
         state_d = RESP;
         if (owner_q) begin
            ack1_d   = 1'b1;
            err1_d   = resp_err;
            rdata1_d = resp_data;
         end else begin
            ack0_d   = 1'b1;
            err0_d   = resp_err;
            rdata0_d = resp_data;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         rr_q      <= 1'b0;
         owner_q   <= 1'b0;
         rw_q      <= 1'b0;
         addr_q    <= 8'h00;
         wdata_q   <= 8'h00;
         start_w_q <= 1'b0;
         start_r_q <= 1'b0;
         hold_q    <= '0;
         tout_q    <= '0;
         done_q    <= 1'b0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         err0_q    <= 1'b0;
         err1_q    <= 1'b0;
         rdata0_q  <= 8'h00;
         rdata1_q  <= 8'h00;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         owner_q   <= owner_d;
         rw_q      <= rw_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         start_w_q <= start_w_d;
         start_r_q <= start_r_d;
         hold_q    <= hold_d;
         tout_q    <= tout_d;
         done_q    <= bus.m_done;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         err0_q    <= err0_d;
         err1_q    <= err1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

   assign bus.m_freq    = bus.cfg_freq;
   assign bus.busy      = (state_q != IDLE);
   assign bus.m_start_w = start_w_q;
   assign bus.m_start_r = start_r_q;
   assign bus.m_addr    = addr_q;
   assign bus.m_wdata   = wdata_q;
   assign bus.ack0      = ack0_q;
   assign bus.ack1      = ack1_q;
   assign bus.err0      = err0_q;
   assign bus.err1      = err1_q;
   assign bus.rdata0    = rdata0_q;
   assign bus.rdata1    = rdata1_q;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb/tb_spi_master_arbiter.sv - directed table plus randomized transactions for spi_master_arbiter
// Expected grants and responses come from a transaction-level round-robin model.
module tb_spi_master_arbiter;
   localparam int START_HOLD = 4;
   localparam int TIMEOUT    = 100;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_master_arbiter_if bus();

   spi_master_arbiter #(.START_HOLD(START_HOLD), .TIMEOUT(TIMEOUT)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      bit         r0, r1, rw0, rw1;
      logic [7:0] a0, a1, w0, w1, srd;
      int         dly;
      bit         eo, er;
      logic [7:0] ea, ew, erd;
      bit         ee;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;
   bit rr = 1'b0;
   vec_t tbl[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input bit r0, r1, rw0, rw1, input logic [7:0] a0, a1, w0, w1,
                               srd, input int dly, input bit eo, er, input logic [7:0] ea, ew,
                               erd, input bit ee);
      vec_t v;
      v.r0 = r0; v.r1 = r1; v.rw0 = rw0; v.rw1 = rw1;
      v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1; v.srd = srd; v.dly = dly;
      v.eo = eo; v.er = er; v.ea = ea; v.ew = ew; v.erd = erd; v.ee = ee;
      return v;
   endfunction

   // reference: winner by round-robin, response from the command and the slave's answer
   function automatic vec_t model(input vec_t v);
      vec_t m = v;
      bit tmo = (v.dly < 0);
      m.eo  = (v.r0 && v.r1) ? rr : !v.r0;
      m.er  = m.eo ? v.rw1 : v.rw0;
      m.ea  = m.eo ? v.a1 : v.a0;
      m.ew  = m.eo ? v.w1 : v.w0;
      m.erd = tmo ? 8'h00 : (m.er ? v.srd : 8'h00);
      m.ee  = tmo;
      return m;
   endfunction

   task automatic run_vec(input vec_t v, input bit rnd);
      int n;
      int k;
      bus.cfg_freq = 10'($urandom);
      bus.req0 = v.r0; bus.rw0 = v.rw0; bus.addr0 = v.a0; bus.wdata0 = v.w0;
      bus.req1 = v.r1; bus.rw1 = v.rw1; bus.addr1 = v.a1; bus.wdata1 = v.w1;
      bus.m_rdata = v.srd;
      #1 chk("m_freq", 32'(bus.m_freq), 32'(bus.cfg_freq));
      step();
      chk("busy_start", bus.busy, 1);
      chk("m_addr", bus.m_addr, v.ea);
      chk("m_wdata", bus.m_wdata, v.ew);
      if (rnd) begin
         bus.rw0 = 1'($urandom); bus.addr0 = 8'($urandom); bus.wdata0 = 8'($urandom);
         bus.rw1 = 1'($urandom); bus.addr1 = 8'($urandom); bus.wdata1 = 8'($urandom);
      end
      n = 0;
      while ((v.er ? bus.m_start_r : bus.m_start_w) && n < 16) begin
         chk("other_start", v.er ? bus.m_start_w : bus.m_start_r, 0);
         chk("ack_in_start", bus.ack0 | bus.ack1, 0);
         chk("addr_held", bus.m_addr, v.ea);
         if (rnd && n == 1) bus.m_done = 1'b1;
         if (rnd && n == 2) bus.m_done = 1'b0;
         n++;
         step();
      end
      chk("start_len", n, START_HOLD);
      if (v.dly >= 0) begin
         for (int i = 0; i < v.dly; i++) begin
            chk("early_ack", bus.ack0 | bus.ack1, 0);
            step();
         end
         bus.m_done = 1'b1;
         step();
      end else begin
         k = 0;
         while (!(bus.ack0 || bus.ack1) && k < TIMEOUT + 20) begin
            step();
            k++;
         end
         chk("timeout_cycles", k, TIMEOUT);
      end
      chk("ack_owner", v.eo ? bus.ack1 : bus.ack0, 1);
      chk("ack_other", v.eo ? bus.ack0 : bus.ack1, 0);
      chk("rdata", v.eo ? bus.rdata1 : bus.rdata0, v.erd);
      chk("err", v.eo ? bus.err1 : bus.err0, v.ee);
      if (v.eo) bus.req1 = 1'b0;
      else      bus.req0 = 1'b0;
      bus.m_done = 1'b0;
      step();
      chk("post_ack", {bus.ack0, bus.ack1, bus.err0, bus.err1, bus.rdata0, bus.rdata1,
                       bus.busy, bus.m_start_w, bus.m_start_r}, 0);
      rr = ~v.eo;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t v;
      int   pick;
      bus.cfg_freq = 10'd4;
      bus.req0 = 0; bus.rw0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
      bus.req1 = 0; bus.rw1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
      bus.m_rdata = 0; bus.m_done = 0;

      tbl[0]  = mk(1,0, 0,0, 8'h12,8'h00, 8'h3C,8'h00, 8'h00, 3,  0,0, 8'h12,8'h3C, 8'h00, 0);
      tbl[1]  = mk(0,1, 0,1, 8'h00,8'h40, 8'h00,8'h00, 8'hA5, 5,  1,1, 8'h40,8'h00, 8'hA5, 0);
      tbl[2]  = mk(1,1, 0,1, 8'h01,8'h02, 8'h11,8'h22, 8'h99, 2,  0,0, 8'h01,8'h11, 8'h00, 0);
      tbl[3]  = mk(0,1, 0,1, 8'h00,8'h02, 8'h00,8'h22, 8'h5A, 1,  1,1, 8'h02,8'h22, 8'h5A, 0);
      tbl[4]  = mk(1,1, 1,0, 8'h10,8'h20, 8'h30,8'h40, 8'h77, 0,  0,1, 8'h10,8'h30, 8'h77, 0);
      tbl[5]  = mk(1,1, 1,0, 8'h10,8'h20, 8'h30,8'h40, 8'h77, 0,  1,0, 8'h20,8'h40, 8'h00, 0);
      tbl[6]  = mk(1,1, 0,1, 8'h50,8'h60, 8'h70,8'h80, 8'h6B, 4,  0,0, 8'h50,8'h70, 8'h00, 0);
      tbl[7]  = mk(1,1, 0,1, 8'h50,8'h60, 8'h70,8'h80, 8'h6B, 4,  1,1, 8'h60,8'h80, 8'h6B, 0);
      tbl[8]  = mk(1,1, 1,1, 8'hAA,8'hBB, 8'hCC,8'hDD, 8'hE1, 2,  0,1, 8'hAA,8'hCC, 8'hE1, 0);
      tbl[9]  = mk(1,1, 1,1, 8'hAA,8'hBB, 8'hCC,8'hDD, 8'hE1, 2,  1,1, 8'hBB,8'hDD, 8'hE1, 0);
      tbl[10] = mk(1,0, 0,0, 8'h77,8'h00, 8'h88,8'h00, 8'hFF, -1, 0,0, 8'h77,8'h88, 8'h00, 1);
      tbl[11] = mk(1,0, 1,0, 8'h33,8'h00, 8'h00,8'h00, 8'hC3, 0,  0,1, 8'h33,8'h00, 8'hC3, 0);
      tbl[12] = mk(1,1, 0,0, 8'hC1,8'hC2, 8'hD1,8'hD2, 8'h00, 2,  0,0, 8'hC1,8'hD1, 8'h00, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", {bus.ack0, bus.ack1, bus.err0, bus.err1, bus.rdata0, bus.rdata1,
                         bus.busy, bus.m_start_w, bus.m_start_r, bus.m_addr, bus.m_wdata}, 0);
      rst_n = 1'b1;
      step();
      bus.m_done = 1'b1;
      step();
      bus.m_done = 1'b0;
      step();
      chk("idle_done_ignored", {bus.busy, bus.ack0, bus.ack1}, 0);

      for (int i = 0; i < 12; i++) run_vec(tbl[i], 1'b0);

      for (int i = 0; i < 40; i++) begin
         pick  = $urandom_range(1, 3);
         v.r0  = pick[0]; v.r1 = pick[1];
         v.rw0 = 1'($urandom); v.rw1 = 1'($urandom);
         v.a0  = 8'($urandom); v.a1 = 8'($urandom);
         v.w0  = 8'($urandom); v.w1 = 8'($urandom);
         v.srd = 8'($urandom);
         v.dly = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 5);
         run_vec(model(v), 1'b1);
      end

      bus.req0 = 1'b0; bus.req1 = 1'b1; bus.rw1 = 1'b1; bus.addr1 = 8'h5E;
      step();
      repeat (START_HOLD + 2) step();
      chk("busy_before_reset", bus.busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_outs", {bus.ack0, bus.ack1, bus.err0, bus.err1, bus.rdata0, bus.rdata1,
                               bus.busy, bus.m_start_w, bus.m_start_r, bus.m_addr,
                               bus.m_wdata}, 0);
      rr = 1'b0;
      #1 rst_n = 1'b1;
      run_vec(tbl[12], 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
